// File: rtl/mem_responder_if.sv
// mem_responder_if: byte-wide CPU memory bus between the memory controller
// (master) and the memory/IO target (slave). Carries the address, write
// strobe, write data, registered read data and the TX back-pressure flag.
interface mem_responder_if;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        io_buffer_full;

  modport master (
    output mem_a,
    output mem_wr,
    output mem_wdata,
    input  mem_rdata,
    input  io_buffer_full
  );

  modport slave (
    input  mem_a,
    input  mem_wr,
    input  mem_wdata,
    output mem_rdata,
    output io_buffer_full
  );
endinterface

// File: rtl/mem_responder.sv
// mem_responder: target end of the CPU byte bus. Single-port byte RAM plus an
// IO window (addr[17:16]==2'b11) holding a UART TX FIFO, status byte, halt
// register and, when MEM_RESP_RX_EN is defined, a UART RX FIFO.
// Reads return data one cycle after the address; rdy_in=0 freezes all state.
module mem_responder #(
  parameter int RAM_ADDR_WIDTH = 17,
  parameter int TX_DEPTH_LOG   = 3,
  parameter int RX_DEPTH_LOG   = 3
) (
  input  logic           clk,
  input  logic           rst_in,
  input  logic           rdy_in,
  mem_responder_if.slave bus,
  output logic           tx_valid,
  output logic [7:0]     tx_data,
  input  logic           tx_ready,
  input  logic           rx_valid,
  input  logic [7:0]     rx_data,
  output logic           rx_ready,
  output logic           halt_out
);
  localparam int TX_DEPTH = 1 << TX_DEPTH_LOG;
  localparam logic [TX_DEPTH_LOG:0]   TX_FULL_CNT = TX_DEPTH;
  localparam logic [TX_DEPTH_LOG:0]   TX_CNT_ONE  = 1;
  localparam logic [TX_DEPTH_LOG-1:0] TX_PTR_ONE  = 1;

  // ---------------- decode ----------------
  logic                      io_s;
  logic [2:0]                off_s;
  logic [RAM_ADDR_WIDTH-1:0] ram_idx_s;
  logic                      ram_wr_s;
  logic                      tx_push_req_s;
  logic                      halt_set_s;
  logic                      data_rd_s;
  logic                      unused_addr_s;

  assign io_s          = (bus.mem_a[17:16] == 2'b11);
  assign off_s         = bus.mem_a[2:0];
  assign ram_idx_s     = bus.mem_a[RAM_ADDR_WIDTH-1:0];
  assign ram_wr_s      = rdy_in && bus.mem_wr && !io_s;
  assign tx_push_req_s = rdy_in && bus.mem_wr && io_s && (off_s == 3'd0);
  assign halt_set_s    = rdy_in && bus.mem_wr && io_s && (off_s == 3'd4);
  assign data_rd_s     = rdy_in && !bus.mem_wr && io_s && (off_s == 3'd0);
  assign unused_addr_s = ^bus.mem_a[31:18];

  // ---------------- RAM ----------------
  logic [7:0] ram_q [0:(1<<RAM_ADDR_WIDTH)-1];

  // RAM write port; contents are intentionally left unreset
  always_ff @(posedge clk) begin
    if (ram_wr_s) ram_q[ram_idx_s] <= bus.mem_wdata;
  end

  // ---------------- TX FIFO ----------------
  logic [7:0]              tx_mem_q [0:TX_DEPTH-1];
  logic [TX_DEPTH_LOG-1:0] tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
  logic [TX_DEPTH_LOG:0]   tx_cnt_q, tx_cnt_d;
  logic                    tx_full_s, tx_pop_s, tx_push_s;

  assign tx_full_s          = (tx_cnt_q == TX_FULL_CNT);
  assign tx_valid           = (tx_cnt_q != '0);
  assign tx_data            = tx_mem_q[tx_rptr_q];
  assign tx_pop_s           = tx_valid && tx_ready && rdy_in;
  // A push into a full FIFO is still accepted when the head leaves on the same edge
  assign tx_push_s          = tx_push_req_s && (!tx_full_s || tx_pop_s);
  // Flags one entry early: the controller may already have a write in flight
  assign bus.io_buffer_full = (tx_cnt_q >= (TX_FULL_CNT - TX_CNT_ONE));

  // TX storage write; entries are only meaningful between the pointers
  always_ff @(posedge clk) begin
    if (tx_push_s) tx_mem_q[tx_wptr_q] <= bus.mem_wdata;
  end

  // TX pointer/count next-state
  always_comb begin
    tx_wptr_d = tx_wptr_q;
    tx_rptr_d = tx_rptr_q;
    tx_cnt_d  = tx_cnt_q;
    if (tx_push_s) tx_wptr_d = tx_wptr_q + TX_PTR_ONE;
    else           tx_wptr_d = tx_wptr_q;
    if (tx_pop_s)  tx_rptr_d = tx_rptr_q + TX_PTR_ONE;
    else           tx_rptr_d = tx_rptr_q;
    case ({tx_push_s, tx_pop_s})
      2'b10:   tx_cnt_d = tx_cnt_q + TX_CNT_ONE;
      2'b01:   tx_cnt_d = tx_cnt_q - TX_CNT_ONE;
      default: tx_cnt_d = tx_cnt_q;
    endcase
  end

  // ---------------- RX FIFO (optional) ----------------
  logic       rx_nonempty_s;
  logic [7:0] rx_head_s;

`ifdef MEM_RESP_RX_EN
  localparam int RX_DEPTH = 1 << RX_DEPTH_LOG;
  localparam logic [RX_DEPTH_LOG:0]   RX_FULL_CNT = RX_DEPTH;
  localparam logic [RX_DEPTH_LOG:0]   RX_CNT_ONE  = 1;
  localparam logic [RX_DEPTH_LOG-1:0] RX_PTR_ONE  = 1;

  logic [7:0]              rx_mem_q [0:RX_DEPTH-1];
  logic [RX_DEPTH_LOG-1:0] rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
  logic [RX_DEPTH_LOG:0]   rx_cnt_q, rx_cnt_d;
  logic                    rx_push_s, rx_pop_s;

  assign rx_nonempty_s = (rx_cnt_q != '0);
  assign rx_ready      = (rx_cnt_q != RX_FULL_CNT);
  assign rx_head_s     = rx_mem_q[rx_rptr_q];
  assign rx_push_s     = rx_valid && rx_ready && rdy_in;
  // Popping an empty FIFO does nothing, even if a byte arrives on the same edge
  assign rx_pop_s      = data_rd_s && rx_nonempty_s;

  // RX storage write from the UART side
  always_ff @(posedge clk) begin
    if (rx_push_s) rx_mem_q[rx_wptr_q] <= rx_data;
  end

  // RX pointer/count next-state
  always_comb begin
    rx_wptr_d = rx_wptr_q;
    rx_rptr_d = rx_rptr_q;
    rx_cnt_d  = rx_cnt_q;
    if (rx_push_s) rx_wptr_d = rx_wptr_q + RX_PTR_ONE;
    else           rx_wptr_d = rx_wptr_q;
    if (rx_pop_s)  rx_rptr_d = rx_rptr_q + RX_PTR_ONE;
    else           rx_rptr_d = rx_rptr_q;
    case ({rx_push_s, rx_pop_s})
      2'b10:   rx_cnt_d = rx_cnt_q + RX_CNT_ONE;
      2'b01:   rx_cnt_d = rx_cnt_q - RX_CNT_ONE;
      default: rx_cnt_d = rx_cnt_q;
    endcase
  end

  // RX pointer/count registers; reset discards queued bytes
  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      rx_wptr_q <= '0;
      rx_rptr_q <= '0;
      rx_cnt_q  <= '0;
    end else begin
      rx_wptr_q <= rx_wptr_d;
      rx_rptr_q <= rx_rptr_d;
      rx_cnt_q  <= rx_cnt_d;
    end
  end
`else
  logic unused_rx_s;
  assign rx_nonempty_s = 1'b0;
  assign rx_head_s     = 8'h00;
  assign rx_ready      = 1'b0;
  assign unused_rx_s   = ^{rx_valid, rx_data};
`endif

  // ---------------- read data / halt ----------------
  logic [7:0] rdata_q, rdata_d;
  logic       halt_q, halt_d;

  // Read-data next-state; status reflects pre-edge FIFO state, writes hold the value
  always_comb begin
    rdata_d = rdata_q;
    if (rdy_in && !bus.mem_wr) begin
      if (!io_s) begin
        rdata_d = ram_q[ram_idx_s];
      end else begin
        case (off_s)
          3'd0: begin
            if (rx_nonempty_s) rdata_d = rx_head_s;
            else               rdata_d = 8'h00;
          end
          3'd4:    rdata_d = {6'b000000, tx_full_s, rx_nonempty_s};
          default: rdata_d = 8'h00;
        endcase
      end
    end else begin
      rdata_d = rdata_q;
    end
  end

  // Halt is sticky until reset
  always_comb begin
    halt_d = halt_q | halt_set_s;
  end

  // Main state registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      rdata_q   <= 8'h00;
      halt_q    <= 1'b0;
      tx_wptr_q <= '0;
      tx_rptr_q <= '0;
      tx_cnt_q  <= '0;
    end else begin
      rdata_q   <= rdata_d;
      halt_q    <= halt_d;
      tx_wptr_q <= tx_wptr_d;
      tx_rptr_q <= tx_rptr_d;
      tx_cnt_q  <= tx_cnt_d;
    end
  end

  assign bus.mem_rdata = rdata_q;
  assign halt_out      = halt_q;
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed scenarios plus randomized traffic checked against a
// queue-based reference model of the RAM, FIFOs, status and halt register.
module tb_mem_responder;
  logic       clk;
  logic       rst_in;
  logic       rdy_in;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic       halt_out;

  mem_responder_if bus();

  mem_responder dut (
    .clk      (clk),
    .rst_in   (rst_in),
    .rdy_in   (rdy_in),
    .bus      (bus),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .tx_ready (tx_ready),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .rx_ready (rx_ready),
    .halt_out (halt_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef MEM_RESP_RX_EN
  localparam bit RX_ON = 1'b1;
`else
  localparam bit RX_ON = 1'b0;
`endif

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [7:0] ram_m [int];
  logic [7:0] txq [$];
  logic [7:0] rxq [$];
  logic [7:0] rdata_m;
  bit         halt_m;

  task automatic model_reset();
    txq.delete();
    rxq.delete();
    rdata_m = 8'h00;
    halt_m  = 1'b0;
  endtask

  // Apply the bus/UART inputs currently driven to the model, as one clock edge
  task automatic model_step();
    logic [31:0] a;
    bit io, tx_full, rx_ne, tx_pop, rx_push;
    logic [2:0] off;
    int idx;
    if (!rdy_in) return;
    a       = bus.mem_a;
    io      = (a[17:16] == 2'b11);
    off     = a[2:0];
    idx     = int'(a[16:0]);
    tx_full = (txq.size() == 8);
    rx_ne   = RX_ON && (rxq.size() != 0);
    tx_pop  = (txq.size() != 0) && tx_ready;
    rx_push = RX_ON && rx_valid && (rxq.size() < 8);
    if (bus.mem_wr) begin
      if (!io) ram_m[idx] = bus.mem_wdata;
      else if (off == 3'd0) begin
        if (!tx_full || tx_pop) txq.push_back(bus.mem_wdata);
      end else if (off == 3'd4) halt_m = 1'b1;
    end else begin
      if (!io) rdata_m = ram_m.exists(idx) ? ram_m[idx] : 8'h00;
      else if (off == 3'd0) begin
        if (rx_ne) rdata_m = rxq.pop_front();
        else       rdata_m = 8'h00;
      end else if (off == 3'd4) rdata_m = {6'b000000, tx_full, rx_ne};
      else rdata_m = 8'h00;
    end
    if (tx_pop)  void'(txq.pop_front());
    if (rx_push) rxq.push_back(rx_data);
  endtask

  task automatic drive(input logic [31:0] a, input logic wr, input logic [7:0] d);
    bus.mem_a     = a;
    bus.mem_wr    = wr;
    bus.mem_wdata = d;
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    checks++; if (bus.mem_rdata !== 8'h00) begin errors++; $display("FAIL reset_rdata: got %h want 00", bus.mem_rdata); end
    checks++; if (halt_out !== 1'b0) begin errors++; $display("FAIL reset_halt: got %b want 0", halt_out); end
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid: got %b want 0", tx_valid); end
    checks++; if (bus.io_buffer_full !== 1'b0) begin errors++; $display("FAIL reset_iofull: got %b want 0", bus.io_buffer_full); end
    checks++; if (rx_ready !== RX_ON) begin errors++; $display("FAIL reset_rx_ready: got %b want %b", rx_ready, RX_ON); end
    rst_in = 1'b1;
  endtask

  task automatic test_ram();
    logic [7:0] pre [4];
    pre = '{8'h11, 8'h22, 8'h33, 8'h44};
    drive(32'h10, 1'b1, 8'hAB); step();
    drive(32'h10, 1'b0, 8'h00); step();
    checks++; if (bus.mem_rdata !== 8'hAB) begin errors++; $display("FAIL ram_raw: got %h want ab", bus.mem_rdata); end
    for (int i = 0; i < 4; i++) begin drive(32'h100 + i, 1'b1, pre[i]); step(); end
    for (int i = 0; i < 4; i++) begin
      drive(32'h100 + i, 1'b0, 8'h00); step();
      checks++; if (bus.mem_rdata !== pre[i]) begin errors++; $display("FAIL ram_seq%0d: got %h want %h", i, bus.mem_rdata, pre[i]); end
    end
    drive(32'h105, 1'b1, 8'h6E); step();
    checks++; if (bus.mem_rdata !== 8'h44) begin errors++; $display("FAIL ram_wr_hold: got %h want 44", bus.mem_rdata); end
    drive(32'h30003, 1'b0, 8'h00);
  endtask

  task automatic test_tx_full();
    tx_ready = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      drive(32'h30000, 1'b1, 8'(i)); step();
      checks++; if (bus.io_buffer_full !== (i >= 7)) begin errors++; $display("FAIL tx_iofull_%0d: got %b want %b", i, bus.io_buffer_full, (i >= 7)); end
    end
    drive(32'h30003, 1'b0, 8'h00);
    tx_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      checks++; if (tx_valid !== 1'b1 || tx_data !== 8'(i)) begin errors++; $display("FAIL tx_drain_%0d: got v=%b d=%h want v=1 d=%h", i, tx_valid, tx_data, 8'(i)); end
      step();
    end
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL tx_empty: got %b want 0", tx_valid); end
    checks++; if (bus.io_buffer_full !== 1'b0) begin errors++; $display("FAIL tx_iofull_clear: got %b want 0", bus.io_buffer_full); end
    tx_ready = 1'b0;
  endtask

  task automatic test_halt_rdy();
    drive(32'h20, 1'b1, 8'h55); step();
    drive(32'h20, 1'b0, 8'h00); step();
    rdy_in = 1'b0;
    drive(32'h30004, 1'b1, 8'h00); step();
    checks++; if (halt_out !== 1'b0) begin errors++; $display("FAIL halt_rdy0: got %b want 0", halt_out); end
    drive(32'h20, 1'b1, 8'h99); step();
    drive(32'h30003, 1'b0, 8'h00); step();
    checks++; if (bus.mem_rdata !== 8'h55) begin errors++; $display("FAIL rdata_hold_rdy0: got %h want 55", bus.mem_rdata); end
    rdy_in = 1'b1;
    drive(32'h20, 1'b0, 8'h00); step();
    checks++; if (bus.mem_rdata !== 8'h55) begin errors++; $display("FAIL ram_rdy0_nowrite: got %h want 55", bus.mem_rdata); end
    drive(32'h30004, 1'b1, 8'h00); step();
    checks++; if (halt_out !== 1'b1) begin errors++; $display("FAIL halt_set: got %b want 1", halt_out); end
    drive(32'h30003, 1'b0, 8'h00);
  endtask

`ifdef MEM_RESP_RX_EN
  task automatic test_rx();
    logic [7:0] exp4 [4];
    exp4 = '{8'h01, 8'h41, 8'h42, 8'h00};
    rx_valid = 1'b1; rx_data = 8'h41; step();
    rx_data = 8'h42; step();
    rx_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive((i == 0) ? 32'h30004 : 32'h30000, 1'b0, 8'h00); step();
      checks++; if (bus.mem_rdata !== exp4[i]) begin errors++; $display("FAIL rx_read%0d: got %h want %h", i, bus.mem_rdata, exp4[i]); end
    end
    drive(32'h30004, 1'b0, 8'h00); step();
    checks++; if (bus.mem_rdata !== 8'h00) begin errors++; $display("FAIL rx_status_empty: got %h want 00", bus.mem_rdata); end
    drive(32'h30000, 1'b0, 8'h00); rx_valid = 1'b1; rx_data = 8'h5A; step();
    checks++; if (bus.mem_rdata !== 8'h00) begin errors++; $display("FAIL rx_simul_pop: got %h want 00", bus.mem_rdata); end
    rx_valid = 1'b0; step();
    checks++; if (bus.mem_rdata !== 8'h5A) begin errors++; $display("FAIL rx_simul_next: got %h want 5a", bus.mem_rdata); end
    drive(32'h30003, 1'b0, 8'h00); rx_valid = 1'b1;
    for (int i = 0; i < 9; i++) begin rx_data = 8'(8'hC0 + i); step(); end
    rx_valid = 1'b0;
    checks++; if (rx_ready !== 1'b0) begin errors++; $display("FAIL rx_full_ready: got %b want 0", rx_ready); end
    drive(32'h30000, 1'b0, 8'h00);
    for (int i = 0; i < 9; i++) begin
      step();
      checks++; if (bus.mem_rdata !== ((i < 8) ? 8'(8'hC0 + i) : 8'h00)) begin errors++; $display("FAIL rx_drain%0d: got %h want %h", i, bus.mem_rdata, ((i < 8) ? 8'(8'hC0 + i) : 8'h00)); end
    end
    checks++; if (rx_ready !== 1'b1) begin errors++; $display("FAIL rx_ready_again: got %b want 1", rx_ready); end
    drive(32'h30003, 1'b0, 8'h00);
  endtask
`else
  task automatic test_rx();
    rx_valid = 1'b1; rx_data = 8'h33;
    drive(32'h30000, 1'b0, 8'h00); step();
    checks++; if (bus.mem_rdata !== 8'h00) begin errors++; $display("FAIL rxoff_data: got %h want 00", bus.mem_rdata); end
    checks++; if (rx_ready !== 1'b0) begin errors++; $display("FAIL rxoff_ready: got %b want 0", rx_ready); end
    drive(32'h30004, 1'b0, 8'h00); step();
    checks++; if (bus.mem_rdata !== 8'h00) begin errors++; $display("FAIL rxoff_status: got %h want 00", bus.mem_rdata); end
    rx_valid = 1'b0;
    drive(32'h30003, 1'b0, 8'h00);
  endtask
`endif

  task automatic test_random();
    int r;
    for (int i = 0; i < 16; i++) begin drive(32'h200 + i, 1'b1, 8'($urandom)); step(); end
    for (int n = 0; n < 400; n++) begin
      rdy_in   = ($urandom_range(0, 9) != 0);
      tx_ready = $urandom_range(0, 1) == 1;
      rx_valid = $urandom_range(0, 1) == 1;
      rx_data  = 8'($urandom);
      r = $urandom_range(0, 3);
      if (r < 2)       drive(32'h200 + $urandom_range(0, 15), $urandom_range(0, 1) == 1, 8'($urandom));
      else if (r == 2) drive(32'h30000, $urandom_range(0, 2) != 0, 8'($urandom));
      else             drive(32'h30000 + $urandom_range(0, 7), $urandom_range(0, 1) == 1, 8'($urandom));
      step();
      checks++; if (bus.mem_rdata !== rdata_m) begin errors++; $display("FAIL rnd_rdata@%0d: got %h want %h", n, bus.mem_rdata, rdata_m); end
      checks++; if (halt_out !== halt_m) begin errors++; $display("FAIL rnd_halt@%0d: got %b want %b", n, halt_out, halt_m); end
      checks++; if (tx_valid !== (txq.size() != 0)) begin errors++; $display("FAIL rnd_tx_valid@%0d: got %b want %b", n, tx_valid, (txq.size() != 0)); end
      if (txq.size() != 0) begin
        checks++; if (tx_data !== txq[0]) begin errors++; $display("FAIL rnd_tx_data@%0d: got %h want %h", n, tx_data, txq[0]); end
      end
      checks++; if (bus.io_buffer_full !== (txq.size() >= 7)) begin errors++; $display("FAIL rnd_iofull@%0d: got %b want %b", n, bus.io_buffer_full, (txq.size() >= 7)); end
      checks++; if (rx_ready !== (RX_ON && rxq.size() < 8)) begin errors++; $display("FAIL rnd_rx_ready@%0d: got %b want %b", n, rx_ready, (RX_ON && rxq.size() < 8)); end
    end
    rdy_in = 1'b1; tx_ready = 1'b0; rx_valid = 1'b0;
    drive(32'h30003, 1'b0, 8'h00);
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin drive(32'h30000, 1'b1, 8'(8'hE0 + i)); step(); end
    drive(32'h30004, 1'b1, 8'h00); step();
    drive(32'h10, 1'b0, 8'h00); step();
    checks++; if (bus.mem_rdata !== 8'hAB || tx_valid !== 1'b1) begin errors++; $display("FAIL pre_reset: got rdata=%h v=%b want ab 1", bus.mem_rdata, tx_valid); end
    drive(32'h30003, 1'b0, 8'h00);
    #3 rst_in = 1'b0;
    #1;
    model_reset();
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL midrst_tx_valid: got %b want 0", tx_valid); end
    checks++; if (bus.mem_rdata !== 8'h00) begin errors++; $display("FAIL midrst_rdata: got %h want 00", bus.mem_rdata); end
    checks++; if (halt_out !== 1'b0) begin errors++; $display("FAIL midrst_halt: got %b want 0", halt_out); end
    checks++; if (bus.io_buffer_full !== 1'b0) begin errors++; $display("FAIL midrst_iofull: got %b want 0", bus.io_buffer_full); end
    #2 rst_in = 1'b1;
    step();
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL postrst_tx_valid: got %b want 0", tx_valid); end
    drive(32'h10, 1'b0, 8'h00); step();
    checks++; if (bus.mem_rdata !== 8'hAB) begin errors++; $display("FAIL ram_survives_reset: got %h want ab", bus.mem_rdata); end
  endtask

  initial begin
    rst_in   = 1'b0;
    rdy_in   = 1'b1;
    tx_ready = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    drive(32'h30003, 1'b0, 8'h00);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_ram();
    test_tx_full();
    test_halt_rdy();
    test_rx();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
